mem_wb_stage: RTL

MEM/WB pipeline stage of the soft CPU. It sits directly downstream of the MEM-stage control registers, including the MemToReg flop, and consumes the MemToReg/RegWrite/rd bundle they produce. It waits on the variable-latency data-memory read, aligns and sign-extends load data, and selects between memory data and the ALU result. It presents one registered write-back beat to the register file and the forwarding unit.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/mem_wb_stage_load_align.sv | 38 +++
 rtl/mem_wb_stage.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants, load-size codes and MEM/WB state encoding.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_WAIT  = 2'b01,
    S_DRAIN = 2'b10
  } state_t;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// load_align: picks the addressed byte/half/word out of a read word and
// zero- or sign-extends it to the full datapath width. Purely combinational.
module load_align
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = rdata[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = lane[addr_lo];
  // addr_lo[0] is irrelevant for halfword loads
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  // select the lane and extend according to size and signedness
  always_comb begin
    data = rdata;
    case (size)
      LS_BYTE: data = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      LS_HALF: data = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline stage. Waits for the variable-latency data
// read, aligns load data, picks memory vs ALU result and emits one registered
// write-back beat. Optional load watchdog enabled by MEM_WB_TIMEOUT_EN.
module mem_wb_stage #(
  parameter int DATA_W      = cpu_pkg::DATA_W,
  parameter int REG_AW      = cpu_pkg::REG_AW,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              in_valid,
  input  logic              in_flush,
  input  logic              in_mem_to_reg,
  input  logic              in_reg_write,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [1:0]        in_addr_lo,
  input  logic [1:0]        in_load_size,
  input  logic              in_load_unsigned,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall_out,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              err
);
  import cpu_pkg::*;

  state_t state_reg, state_next;

  logic [REG_AW-1:0] rd_reg;
  logic              reg_write_reg;
  logic [1:0]        addr_lo_reg;
  logic [1:0]        load_size_reg;
  logic              load_unsigned_reg;

  logic              accept;
  logic              timeout_hit;

  logic [1:0]        al_addr_lo;
  logic [1:0]        al_size;
  logic              al_unsigned;
  logic [DATA_W-1:0] al_data;

  logic              beat_next;
  logic              we_next;
  logic              err_set;
  logic [REG_AW-1:0] rd_next;
  logic [DATA_W-1:0] data_next;

  assign accept = (state_reg == S_IDLE) && in_valid && !in_flush;

  // In IDLE the aligner sees the live MEM fields (same-cycle load); while
  // waiting it sees the fields captured at accept time.
  assign al_addr_lo  = (state_reg == S_IDLE) ? in_addr_lo       : addr_lo_reg;
  assign al_size     = (state_reg == S_IDLE) ? in_load_size     : load_size_reg;
  assign al_unsigned = (state_reg == S_IDLE) ? in_load_unsigned : load_unsigned_reg;

  load_align u_load_align (
    .rdata       (dmem_rdata),
    .addr_lo     (al_addr_lo),
    .size        (al_size),
    .is_unsigned (al_unsigned),
    .data        (al_data)
  );

`ifdef MEM_WB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);
  logic [7:0] cnt_reg;
  logic       err_reg;

  // watchdog counter: restarts on entering WAIT/DRAIN, counts while there
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt_reg <= '0;
    end else if (state_next != state_reg && state_next != S_IDLE) begin
      cnt_reg <= '0;
    end else if (state_reg != S_IDLE) begin
      cnt_reg <= cnt_reg + 8'd1;
    end
  end

  // sticky timeout flag
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      err_reg <= 1'b0;
    end else if (err_set) begin
      err_reg <= 1'b1;
    end
  end

  assign timeout_hit = (cnt_reg == TIMEOUT_LIM);
  assign err         = err_reg;
`else
  logic [7:0] unused_timeout_cyc;
  assign unused_timeout_cyc = 8'(TIMEOUT_CYC);
  assign timeout_hit        = 1'b0;
  assign err                = 1'b0;
`endif

  // state register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // next-state logic; read data has priority over flush and timeout in WAIT
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept && in_mem_to_reg && !dmem_rvalid) state_next = S_WAIT;
      S_WAIT: begin
        if (dmem_rvalid)      state_next = S_IDLE;
        else if (in_flush)    state_next = S_DRAIN;
        else if (timeout_hit) state_next = S_IDLE;
      end
      S_DRAIN: if (dmem_rvalid || timeout_hit) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // beat decode: whether a write-back completes this cycle and with what
  always_comb begin
    beat_next = 1'b0;
    we_next   = 1'b0;
    err_set   = 1'b0;
    rd_next   = rd_reg;
    data_next = al_data;
    case (state_reg)
      S_IDLE: begin
        if (accept && (!in_mem_to_reg || dmem_rvalid)) begin
          beat_next = 1'b1;
          rd_next   = in_rd;
          we_next   = in_reg_write && (in_rd != '0);
          if (!in_mem_to_reg) data_next = in_alu_result;
        end
      end
      S_WAIT: begin
        if (dmem_rvalid && !in_flush) begin
          beat_next = 1'b1;
          we_next   = reg_write_reg && (rd_reg != '0);
        end else if (!dmem_rvalid && !in_flush && timeout_hit) begin
          beat_next = 1'b1;
          data_next = '0;
          err_set   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // capture control of an accepted instruction for the WAIT path
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rd_reg            <= '0;
      reg_write_reg     <= 1'b0;
      addr_lo_reg       <= '0;
      load_size_reg     <= '0;
      load_unsigned_reg <= 1'b0;
    end else if (accept) begin
      rd_reg            <= in_rd;
      reg_write_reg     <= in_reg_write;
      addr_lo_reg       <= in_addr_lo;
      load_size_reg     <= in_load_size;
      load_unsigned_reg <= in_load_unsigned;
    end
  end

  // registered write-back beat and stall; rd/data hold between beats
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      stall_out <= 1'b0;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
    end else begin
      stall_out <= (state_next != S_IDLE);
      wb_valid  <= beat_next;
      wb_we     <= beat_next && we_next;
      if (beat_next) begin
        wb_rd   <= rd_next;
        wb_data <= data_next;
      end
    end
  end

endmodule
